// File: rtl/qoi_pkg.sv
// Shared QOI constants: chunk opcodes, end-marker bytes and the byte packer state type.
package qoi_pkg;

    localparam logic [7:0] QOI_OP_INDEX = 8'h00;
    localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
    localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
    localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
    localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
    localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
    localparam logic [7:0] QOI_MASK_2   = 8'hC0;

    localparam int         QOI_END_LEN  = 8;
    localparam logic [7:0] QOI_END_PAD  = 8'h00;
    localparam logic [7:0] QOI_END_LAST = 8'h01;

    localparam int         QOI_MAX_CHUNK = 4;

    typedef enum logic [1:0] {
        STREAM,
        TRAILER,
        DRAIN
    } packer_state_t;

endpackage

// File: rtl/qoi_byte_fifo.sv
// Byte FIFO with a last-tag bit per entry; accepts up to four ordered writes and one read per cycle.
module qoi_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               i_wrCount,
    input  logic [3:0][8:0]          i_wrData,
    input  logic                     i_rdEn,
    output logic [8:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [8:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    // Storage has no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < i_wrCount) begin
                r_mem[r_wrPtr + PW'(k)] <= i_wrData[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + PW'(i_wrCount);
            r_rdPtr <= r_rdPtr + PW'(i_rdEn);
            r_count <= r_count + CW'(i_wrCount) - CW'(i_rdEn);
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/qoi_byte_packer.sv
// Serializes MSB-aligned QOI chunks into a byte stream and appends the 8-byte end marker per image.
module qoi_byte_packer
    import qoi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [31:0] byte_count,
    output logic        err
);

    localparam int CW = $clog2(DEPTH) + 1;

    packer_state_t   r_state;
    packer_state_t   w_nextState;
    logic [2:0]      r_trailIdx;
    logic [31:0]     r_byteCount;
    logic            r_err;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_free;
    logic [8:0]      w_head;
    logic [2:0]      w_wrCount;
    logic [3:0][8:0] w_wrData;
    logic [2:0]      w_nBytes;
    logic            w_accept;
    logic            w_pop;
    logic            w_lastPop;
    logic            w_trailPush;
    logic            w_trailFinal;

    qoi_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_wrCount(w_wrCount),
        .i_wrData (w_wrData),
        .i_rdEn   (w_pop),
        .o_head   (w_head),
        .o_count  (w_count)
    );

    assign w_free       = CW'(DEPTH) - w_count;
    assign in_ready     = !rst && (r_state == STREAM) && (w_free >= CW'(QOI_MAX_CHUNK));
    assign w_accept     = in_valid && in_ready;
    assign w_nBytes     = (in_bytes > 3'(QOI_MAX_CHUNK)) ? 3'(QOI_MAX_CHUNK) : in_bytes;

    assign out_valid    = (w_count != '0);
    assign out_byte     = out_valid ? w_head[7:0] : 8'h00;
    assign out_last     = out_valid && w_head[8];
    assign w_pop        = out_valid && out_ready;
    assign w_lastPop    = w_pop && w_head[8];
    assign w_trailFinal = (r_trailIdx == 3'(QOI_END_LEN - 1));

    assign byte_count   = r_byteCount;
    assign err          = r_err;

    // A trailer slot is free if the FIFO is not full or the head leaves this cycle.
    always_comb begin
        w_nextState = r_state;
        w_wrCount   = 3'd0;
        w_wrData    = '0;
        w_trailPush = 1'b0;
        case (r_state)
            STREAM: begin
                if (w_accept) begin
                    w_wrCount   = w_nBytes;
                    w_wrData[0] = {1'b0, in_data[31:24]};
                    w_wrData[1] = {1'b0, in_data[23:16]};
                    w_wrData[2] = {1'b0, in_data[15:8]};
                    w_wrData[3] = {1'b0, in_data[7:0]};
                    if (in_last) begin
                        w_nextState = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if ((w_count != CW'(DEPTH)) || w_pop) begin
                    w_trailPush = 1'b1;
                    w_wrCount   = 3'd1;
                    w_wrData[0] = {w_trailFinal, w_trailFinal ? QOI_END_LAST : QOI_END_PAD};
                    if (w_trailFinal) begin
                        w_nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_lastPop) begin
                    w_nextState = STREAM;
                end
            end
            default: begin
                w_nextState = STREAM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= STREAM;
            r_trailIdx  <= 3'd0;
            r_byteCount <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_trailPush) begin
                r_trailIdx <= r_trailIdx + 3'd1;
            end
            // The end-marker pop closes the image, so the count restarts rather than counting it.
            if (w_lastPop && (r_state == DRAIN)) begin
                r_byteCount <= 32'd0;
            end else if (w_pop) begin
                r_byteCount <= r_byteCount + 32'd1;
            end
            if (w_accept && (in_bytes > 3'(QOI_MAX_CHUNK))) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/qoi_byte_packer.md
# qoi_byte_packer

Serializes the variable-length chunks produced by the QOI encoder stage (up to 4 bytes per cycle, MSB-aligned in a 32-bit word) into a one-byte-per-cycle output stream with valid/ready flow control. It sits directly downstream of the encoder and upstream of the file/DMA writer. It buffers bytes in an internal FIFO and appends the 8-byte QOI end marker (seven 0x00 bytes, then 0x01) after the last chunk of an image. It also counts emitted bytes.

## Interface
- DEPTH, 16, byte FIFO depth; power of two, ≥ 8.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  chunk bytes, MSB-aligned; in_data[31:24] is the first byte.
- in_bytes  in  3  valid byte count in in_data, 0..4.
- in_last  in  1  chunk is the final chunk of the image.
- in_valid  in  1  chunk present.
- in_ready  out  1  packer can accept a chunk this cycle.
- out_byte  out  8  output byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  downstream accepts out_byte.
- out_last  out  1  out_byte is the final 0x01 of the end marker.
- byte_count  out  32  total bytes emitted since reset or since the last image ended; wraps modulo 2^32.
- err  out  1  sticky; set when a chunk with in_bytes > 4 is accepted.

## Operation
- Reset values: in_ready=0 for the cycle rst is high, then follows the rules below. out_valid=0, out_last=0, out_byte=0, byte_count=0, err=0. FIFO is empty and the state is STREAM.
- FIFO occupancy is count, width $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- in_ready = (state==STREAM) && (DEPTH − count ≥ 4). It depends only on registered state and never on in_valid.
- Accept: in_valid && in_ready. Write in_bytes bytes in order in_data[31:24], [23:16], [15:8], [7:0].
  - in_bytes=0: accepted with no write. in_last is still honoured.
  - in_bytes 5..7: handled as 4, and err is set.
- Pop: out_valid && out_ready. It advances the read pointer and increments byte_count.
- Simultaneous push and pop in one cycle: count changes by (bytes written − 1).
- State machine:
  - STREAM → TRAILER on accepting a chunk with in_last=1.
  - TRAILER: pushes the trailer bytes one per cycle while count < DEPTH (after accounting for a same-cycle pop). A 3-bit index runs 0..7; bytes 0..6 are 0x00 and byte 7 is 0x01. After pushing byte 7, go to DRAIN.
  - DRAIN: when the 0x01 byte pops, go to STREAM and clear byte_count to 0 in that same cycle.
- out_last=1 exactly when out_valid and the head byte is trailer byte 7. A tag bit is stored with each FIFO entry.
- out_byte and out_last hold stable while out_valid && !out_ready.
- Reset mid-operation (any state): FIFO is discarded and all outputs return to reset values. err is cleared only by rst.

## Timing
- Bytes written in cycle N are visible on out_byte in cycle N+1 at the earliest. When the FIFO was empty, the first chunk byte appears at N+1.
- Sustained throughput is 1 byte/cycle output. Input rate is limited by in_ready.
- The first trailer byte is pushed in the cycle after the in_last chunk is accepted.
- in_ready is low from the cycle after in_last acceptance until the cycle after the 0x01 pops. The first chunk of the next image can be accepted in that following cycle.
- byte_count updates in the cycle after the pop.

## Structure
- Shared package qoi_pkg holds:
  - the QOI_OP_* opcode constants and QOI_MASK_2;
  - QOI_END_LEN=8 and the end-marker byte values;
  - QOI_MAX_CHUNK=4;
  - the packer state enum (STREAM, TRAILER, DRAIN).
- One sub-module: qoi_byte_fifo (DEPTH × 9 bits, data plus last tag; up to 4 writes and 1 read per cycle; count output). The packer top holds the FSM, trailer index, byte_count and err.

## Test plan
- Single chunk 0xFE112233 with in_bytes=4 and out_ready=1 → bytes FE, 11, 22, 33 on consecutive cycles starting the cycle after acceptance; byte_count=4.
- Back-to-back chunks of 1 byte (0x6A000000) with out_ready=1 → one 0x6A per cycle with no gaps; in_ready stays high.
- out_ready=0 with repeated 4-byte chunks → in_ready drops when count > DEPTH−4 (count=13 for DEPTH=16). Nothing is lost. out_byte holds steady.
- Chunk 0x55000000, in_bytes=1, in_last=1 → stream 55, then 00×7, then 01. out_last is high only on 01. in_ready is low until the cycle after 01 pops. byte_count clears to 0.
- in_bytes=6 with in_data=0xAABBCCDD → 4 bytes AA, BB, CC, DD are emitted and err=1 until rst.
- rst asserted during TRAILER with a half-full FIFO → next cycle out_valid=0, byte_count=0, state STREAM. A new chunk is accepted normally.
